// File: rtl/scale_seq_pkg.sv
// scale_seq shared definitions
// sequencer states, 720p geometry, scale limit
package definePackage;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } seq_state_t;

  localparam int ACT_W_720     = 1280;
  localparam int ACT_H_720     = 720;
  localparam int MAX_SCALE_DEF = 4;

  function automatic logic [11:0] win_span(
    input int         src,
    input logic [2:0] s
  );
    return 12'(src) * {9'd0, s};
  endfunction

  function automatic logic [11:0] win_start(
    input int         act,
    input int         src,
    input logic [2:0] s
  );
    return (12'(act) - win_span(src, s)) >> 1;
  endfunction

endpackage

// File: rtl/scale_seq_delay_line.sv
// scale_seq fixed-depth register delay
// resets every tap to zero
module delayLine #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             pxlClk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] tap [DEPTH];

  // shift din through DEPTH taps
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++)
        tap[i] <= '0;
    end else begin
      tap[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        tap[i] <= tap[i-1];
    end
  end

  assign dout = tap[DEPTH-1];

endmodule

// File: rtl/scale_seq.sv
// scale_seq: integer upscaler sequencer
// centres a SRC_WxSRC_H source in the active output
module scale_seq
  import definePackage::*;
#(
  parameter int SRC_W     = 240,
  parameter int SRC_H     = 160,
  parameter int ACT_W     = ACT_W_720,
  parameter int ACT_H     = ACT_H_720,
  parameter int MAX_SCALE = MAX_SCALE_DEF,
  parameter int PIPE_DEL  = 2,
  parameter int PREFETCH  = 8
) (
  input  logic        pxlClk,
  input  logic        rstN,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  input  logic [10:0] frameWidth,
  input  logic [9:0]  frameHeight,
  input  logic [2:0]  scaleSel,
  input  logic        newFrameIn,
  input  logic        sameLine,
  output logic        drawActive,
  output logic [7:0]  curPxl,
  output logic [2:0]  xPhase,
  output logic [2:0]  yPhase,
  output logic        nextLine,
  output logic        cacheUpdate,
  output logic        setStart,
  output logic [10:0] setStartX,
  output logic [9:0]  setStartY,
  output logic [2:0]  curScale,
  output logic        locked
);

  localparam logic [2:0] SMAX = 3'(MAX_SCALE);

  seq_state_t  state;
  seq_state_t  state_n;
  logic        nf_q;
  logic [10:0] cx_q;
  logic [9:0]  cy_q;
  logic        rise;
  logic        scale_ok;
  logic [2:0]  scale_n;
  logic [11:0] x_start;
  logic [11:0] y_start;
  logic [11:0] x_start_n;
  logic [11:0] y_start_n;
  logic [11:0] x_end;
  logic [11:0] y_end;
  logic [11:0] cx_w;
  logic [11:0] cy_w;
  logic [2:0]  last_ph;
  logic [2:0]  x_ph;
  logic [2:0]  x_ph_vis;
  logic [7:0]  pxl_cnt;
  logic [2:0]  y_ph;
  logic        line_end;
  logic        frame_end;
  logic        past_top;

  assign rise      = newFrameIn & ~nf_q;
  assign scale_ok  = (scaleSel != 3'd0) &&
                     (32'(scaleSel) <= 32'(MAX_SCALE));
  assign scale_n   = scale_ok ? scaleSel : SMAX;
  assign x_start_n = win_start(ACT_W, SRC_W, scale_n);
  assign y_start_n = win_start(ACT_H, SRC_H, scale_n);

  assign cx_w  = {1'b0, cx};
  assign cy_w  = {2'b0, cy};
  assign x_end = x_start + win_span(SRC_W, curScale);
  assign y_end = y_start + win_span(SRC_H, curScale);

  assign drawActive = (cx_w >= x_start) && (cx_w < x_end) &&
                      (cy_w >= y_start) && (cy_w < y_end);

  assign last_ph   = curScale - 3'd1;
  assign line_end  = (cx == frameWidth - 11'd1);
  assign frame_end = (cy == frameHeight - 10'd1);
  assign past_top  = (cy_w >= y_start);

  // input history for edge and change detection
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      nf_q <= 1'b0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      nf_q <= newFrameIn;
      cx_q <= cx;
      cy_q <= cy;
    end
  end

  // sequencer state register
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN)
      state <= IDLE;
    else
      state <= state_n;
  end

  // next state: a frame edge always wins over the sync exit
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (rise) state_n = SYNC;
      SYNC: begin
        if (rise)
          state_n = SYNC;
        else if (cy != cy_q)
          state_n = RUN;
      end
      RUN:  if (rise) state_n = SYNC;
      default: state_n = IDLE;
    endcase
  end

  // per-frame geometry, counter preset and lock status
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      curScale  <= SMAX;
      x_start   <= win_start(ACT_W, SRC_W, SMAX);
      y_start   <= win_start(ACT_H, SRC_H, SMAX);
      setStart  <= 1'b0;
      setStartX <= '0;
      setStartY <= '0;
      locked    <= 1'b0;
    end else begin
      if (rise) begin
        curScale  <= scale_n;
        x_start   <= x_start_n;
        y_start   <= y_start_n;
        setStartY <= 10'(y_start_n - 12'd2);
      end
      setStartX <= '0;
      setStart  <= (state_n == SYNC);
      locked    <= (state == RUN);
    end
  end

  // horizontal phase and source pixel, held at zero off-window
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      x_ph    <= '0;
      pxl_cnt <= '0;
    end else if (!drawActive) begin
      x_ph    <= '0;
      pxl_cnt <= '0;
    end else if (x_ph == last_ph) begin
      x_ph    <= '0;
      pxl_cnt <= pxl_cnt + 8'd1;
    end else begin
      x_ph    <= x_ph + 3'd1;
    end
  end

  assign x_ph_vis = drawActive ? x_ph : 3'd0;
  assign curPxl   = drawActive ? pxl_cnt : 8'd0;

  delayLine #(
    .WIDTH (3),
    .DEPTH (PIPE_DEL)
  ) u_xph_dly (
    .pxlClk (pxlClk),
    .rstN   (rstN),
    .din    (x_ph_vis),
    .dout   (xPhase)
  );

  // vertical phase, stepped once per output line
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN)
      y_ph <= '0;
    else if (line_end) begin
      if (frame_end || state == SYNC)
        y_ph <= '0;
      else if (y_ph == last_ph)
        y_ph <= '0;
      else if (past_top)
        y_ph <= y_ph + 3'd1;
    end
  end

  assign yPhase      = y_ph;
  assign cacheUpdate = (cx_q == frameWidth - 11'(PREFETCH));
  assign nextLine    = cacheUpdate && !sameLine &&
                       (state == RUN) && past_top &&
                       (y_ph == last_ph);

endmodule

// File: tb/tb_scale_seq.sv
// tb_scale_seq: scoreboard bench for scale_seq
// stimulus queues expectations, negedge monitor checks
module tb_scale_seq;

  logic        pxlClk;
  logic        rstN;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic [10:0] frameWidth;
  logic [9:0]  frameHeight;
  logic [2:0]  scaleSel;
  logic        newFrameIn;
  logic        sameLine;
  logic        drawActive;
  logic [7:0]  curPxl;
  logic [2:0]  xPhase;
  logic [2:0]  yPhase;
  logic        nextLine;
  logic        cacheUpdate;
  logic        setStart;
  logic [10:0] setStartX;
  logic [9:0]  setStartY;
  logic [2:0]  curScale;
  logic        locked;

  scale_seq dut (
    .pxlClk      (pxlClk),
    .rstN        (rstN),
    .cx          (cx),
    .cy          (cy),
    .frameWidth  (frameWidth),
    .frameHeight (frameHeight),
    .scaleSel    (scaleSel),
    .newFrameIn  (newFrameIn),
    .sameLine    (sameLine),
    .drawActive  (drawActive),
    .curPxl      (curPxl),
    .xPhase      (xPhase),
    .yPhase      (yPhase),
    .nextLine    (nextLine),
    .cacheUpdate (cacheUpdate),
    .setStart    (setStart),
    .setStartX   (setStartX),
    .setStartY   (setStartY),
    .curScale    (curScale),
    .locked      (locked)
  );

  localparam int F_DRAW = 0;
  localparam int F_PXL  = 1;
  localparam int F_XPH  = 2;
  localparam int F_YPH  = 3;
  localparam int F_NL   = 4;
  localparam int F_CU   = 5;
  localparam int F_SS   = 6;
  localparam int F_SSX  = 7;
  localparam int F_SSY  = 8;
  localparam int F_SCL  = 9;
  localparam int F_LCK  = 10;

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  initial begin
    pxlClk = 1'b0;
    forever #5 pxlClk = ~pxlClk;
  end

  function automatic int act(input int f);
    case (f)
      F_DRAW:  return int'(drawActive);
      F_PXL:   return int'(curPxl);
      F_XPH:   return int'(xPhase);
      F_YPH:   return int'(yPhase);
      F_NL:    return int'(nextLine);
      F_CU:    return int'(cacheUpdate);
      F_SS:    return int'(setStart);
      F_SSX:   return int'(setStartX);
      F_SSY:   return int'(setStartY);
      F_SCL:   return int'(curScale);
      F_LCK:   return int'(locked);
      default: return -1;
    endcase
  endfunction

  always @(negedge pxlClk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (mon_e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: stale entry cyc %0d now %0d",
                 mon_e.name, mon_e.cyc, cyc);
      end else if (act(mon_e.fld) != mon_e.val) begin
        n_bad++;
        $display("FAIL %s: got %0d want %0d",
                 mon_e.name, act(mon_e.fld), mon_e.val);
      end
    end
  end

  task automatic step(input int x, input int y);
    @(posedge pxlClk);
    #1;
    cyc++;
    cx = 11'(x);
    cy = 10'(y);
  endtask

  task automatic ex(input int f, input int v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.fld  = f;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc         = 0;
    n_cmp       = 0;
    n_bad       = 0;
    rstN        = 1'b1;
    cx          = '0;
    cy          = '0;
    frameWidth  = 11'd1650;
    frameHeight = 10'd750;
    scaleSel    = 3'd4;
    newFrameIn  = 1'b0;
    sameLine    = 1'b0;
    #1 rstN = 1'b0;

    // reset state
    step(0, 0);
    step(0, 0);
    ex(F_SCL, 4, "rst_scale");
    ex(F_LCK, 0, "rst_locked");
    ex(F_SS, 0, "rst_setstart");
    ex(F_SSY, 0, "rst_ssy");
    ex(F_PXL, 0, "rst_pxl");
    ex(F_YPH, 0, "rst_yph");
    ex(F_XPH, 0, "rst_xph");
    step(0, 0);
    rstN = 1'b1;
    step(0, 0);
    step(0, 0);
    step(0, 0);
    ex(F_SS, 0, "idle_setstart");
    ex(F_LCK, 0, "idle_locked");

    // first sync at scale 4
    step(0, 749);
    newFrameIn = 1'b1;
    ex(F_SS, 0, "sync_pre");
    step(0, 749);
    ex(F_SS, 1, "sync_ss");
    ex(F_SSX, 0, "sync_ssx");
    ex(F_SSY, 38, "sync_ssy");
    ex(F_SCL, 4, "sync_scale");
    ex(F_LCK, 0, "sync_lck");
    step(0, 749);
    ex(F_SS, 1, "sync_hold");
    step(0, 0);
    newFrameIn = 1'b0;
    ex(F_SS, 1, "sync_hold2");
    step(0, 0);
    ex(F_SS, 0, "sync_exit");
    ex(F_LCK, 0, "sync_lck_lag");
    step(0, 0);
    ex(F_LCK, 1, "run_locked");

    // horizontal sweep on line 40
    for (int x = 158; x <= 1121; x++) begin
      step(x, 40);
      if (x == 159) ex(F_DRAW, 0, "x159_draw");
      if (x == 160) ex(F_DRAW, 1, "x160_draw");
      if (x == 160) ex(F_PXL, 0, "x160_pxl");
      if (x == 164) ex(F_PXL, 1, "x164_pxl");
      if (x == 164) ex(F_XPH, 2, "x164_xph");
      if (x == 165) ex(F_XPH, 3, "x165_xph");
      if (x == 1119) ex(F_DRAW, 1, "x1119_draw");
      if (x == 1119) ex(F_PXL, 239, "x1119_pxl");
      if (x == 1120) ex(F_DRAW, 0, "x1120_draw");
      if (x == 1120) ex(F_PXL, 0, "x1120_pxl");
    end

    // vertical window edges
    step(500, 39);
    ex(F_DRAW, 0, "y39_draw");
    step(500, 40);
    ex(F_DRAW, 1, "y40_draw");
    step(500, 679);
    ex(F_DRAW, 1, "y679_draw");
    step(500, 680);
    ex(F_DRAW, 0, "y680_draw");
    step(159, 679);
    ex(F_DRAW, 0, "x159y679_draw");

    // y phase, cache strobe and line advance
    step(1649, 40);
    step(1642, 41);
    ex(F_YPH, 1, "yph1");
    step(1643, 41);
    ex(F_CU, 1, "cu_yph1");
    ex(F_NL, 0, "nl_yph1");
    step(1649, 41);
    step(1649, 42);
    step(1642, 43);
    ex(F_YPH, 3, "yph3");
    ex(F_CU, 0, "cu_pre");
    step(1643, 43);
    sameLine = 1'b1;
    ex(F_CU, 1, "cu_same");
    ex(F_NL, 0, "nl_same");
    step(1644, 43);
    sameLine = 1'b0;
    ex(F_CU, 0, "cu_after");
    ex(F_NL, 0, "nl_after");
    step(1642, 43);
    step(1643, 43);
    ex(F_CU, 1, "cu_adv");
    ex(F_NL, 1, "nl_adv");
    step(1644, 43);
    ex(F_NL, 0, "nl_one_cycle");
    step(1649, 43);
    step(0, 44);
    ex(F_YPH, 0, "yph_wrap");

    // mid-frame scale request waits for the frame edge
    step(500, 100);
    scaleSel = 3'd3;
    step(0, 100);
    ex(F_SCL, 4, "mid_scale");
    step(160, 100);
    ex(F_DRAW, 1, "mid_draw160");
    step(0, 749);
    newFrameIn = 1'b1;
    step(0, 749);
    ex(F_SCL, 3, "s3_scale");
    ex(F_SS, 1, "s3_ss");
    ex(F_SSY, 118, "s3_ssy");
    ex(F_LCK, 1, "s3_lck_lag");
    step(0, 749);
    newFrameIn = 1'b0;
    ex(F_LCK, 0, "s3_lck_drop");
    step(0, 0);
    ex(F_SS, 1, "s3_hold");
    step(0, 0);
    ex(F_SS, 0, "s3_exit");
    step(0, 0);
    ex(F_LCK, 1, "s3_locked");
    step(279, 200);
    ex(F_DRAW, 0, "s3_x279");
    for (int x = 280; x <= 286; x++) begin
      step(x, 200);
      if (x == 280) ex(F_DRAW, 1, "s3_x280");
      if (x == 282) ex(F_XPH, 0, "s3_xph282");
      if (x == 283) ex(F_XPH, 1, "s3_xph283");
      if (x == 284) ex(F_XPH, 2, "s3_xph284");
      if (x == 285) ex(F_XPH, 0, "s3_xph285");
      if (x == 286) ex(F_XPH, 1, "s3_xph286");
      if (x == 283) ex(F_PXL, 1, "s3_pxl283");
    end
    step(999, 200);
    ex(F_DRAW, 1, "s3_x999");
    step(1000, 200);
    ex(F_DRAW, 0, "s3_x1000");
    step(500, 119);
    ex(F_DRAW, 0, "s3_y119");
    step(500, 120);
    ex(F_DRAW, 1, "s3_y120");
    step(500, 599);
    ex(F_DRAW, 1, "s3_y599");
    step(500, 600);
    ex(F_DRAW, 0, "s3_y600");

    // frame edge coinciding with sync exit
    step(0, 749);
    newFrameIn = 1'b1;
    step(0, 749);
    newFrameIn = 1'b0;
    step(0, 749);
    step(0, 0);
    newFrameIn = 1'b1;
    scaleSel   = 3'd2;
    step(0, 0);
    ex(F_SS, 1, "race_ss");
    ex(F_SCL, 2, "race_scale");
    ex(F_SSY, 198, "race_ssy");
    step(0, 0);
    newFrameIn = 1'b0;
    ex(F_SS, 1, "race_hold");
    ex(F_LCK, 0, "race_lck");
    step(0, 5);
    ex(F_SS, 1, "race_hold2");
    step(0, 5);
    ex(F_SS, 0, "race_exit");
    step(0, 5);
    ex(F_LCK, 1, "race_locked");

    // out-of-range scale requests
    step(0, 749);
    newFrameIn = 1'b1;
    scaleSel   = 3'd0;
    step(0, 749);
    newFrameIn = 1'b0;
    ex(F_SCL, 4, "sel0_scale");
    ex(F_SSY, 38, "sel0_ssy");
    step(0, 749);
    newFrameIn = 1'b1;
    scaleSel   = 3'd1;
    step(0, 749);
    newFrameIn = 1'b0;
    ex(F_SCL, 1, "sel1_scale");
    ex(F_SSY, 278, "sel1_ssy");
    step(0, 749);
    newFrameIn = 1'b1;
    scaleSel   = 3'd7;
    step(0, 749);
    newFrameIn = 1'b0;
    scaleSel   = 3'd4;
    ex(F_SCL, 4, "sel7_scale");
    step(0, 0);
    step(0, 0);
    step(0, 0);
    ex(F_LCK, 1, "sel7_locked");

    // asynchronous reset mid-line while running
    step(1649, 40);
    step(1649, 41);
    step(1649, 42);
    for (int x = 500; x <= 505; x++) step(x, 100);
    ex(F_XPH, 3, "pre_rst_xph");
    ex(F_PXL, 1, "pre_rst_pxl");
    ex(F_YPH, 3, "pre_rst_yph");
    ex(F_LCK, 1, "pre_rst_lck");
    step(506, 100);
    #1 rstN = 1'b0;
    ex(F_PXL, 0, "arst_pxl");
    ex(F_XPH, 0, "arst_xph");
    ex(F_YPH, 0, "arst_yph");
    ex(F_LCK, 0, "arst_lck");
    ex(F_SS, 0, "arst_ss");
    step(0, 0);
    rstN = 1'b1;
    step(0, 0);
    ex(F_SS, 0, "post_rst_ss");
    step(1649, 40);
    step(1649, 41);
    step(1649, 42);
    step(1642, 43);
    step(1643, 43);
    ex(F_CU, 1, "idle_cu");
    ex(F_YPH, 3, "idle_yph");
    ex(F_NL, 0, "idle_nl");
    ex(F_LCK, 0, "idle_lck");
    step(0, 0);
    step(0, 0);

    if (sb.size() != 0) begin
      $display("FAIL leftover: %0d unchecked, want 0", sb.size());
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
